// File: rtl/mips_bus_pkg.sv
// Shared types and default widths for the MIPS bus arbiter slice.
package mips_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_CH     = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

    // Channel that follows the winner in round-robin order.
    function automatic ch_idx_t next_ch(input int winner, input int num_ch);
        return (winner + 1 >= num_ch) ? '0 : ch_idx_t'(winner + 1);
    endfunction

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Combinational grant picker: first requester at or after ptr, wrapping, wins.
module mips_bus_arb_pick
    import mips_bus_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           ptr,
    output logic [NUM_CH-1:0] grant
);

    // Walk from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req[i] && ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_CH))) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// N-channel to single-master bus arbiter with lock-on-stall and read return routing.
// Define MIPS_BUS_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
    input  logic [NUM_CH*DATA_W-1:0]   ch_writedata,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_byteenable,
    output logic [NUM_CH-1:0]          ch_waitrequest,
    output logic [NUM_CH-1:0]          ch_readdatavalid,
    output logic [DATA_W-1:0]          ch_readdata,
    output logic                       read,
    output logic                       write,
    output logic [ADDR_W-1:0]          address,
    output logic [DATA_W-1:0]          writedata,
    output logic [DATA_W/8-1:0]        byteenable,
    input  logic                       waitrequest,
    input  logic [DATA_W-1:0]          readdata,
    output logic                       proto_err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state, state_nxt;
    logic                armed;
    logic [NUM_CH-1:0]   req, both, pick_grant, lock_grant, grant;
    ch_idx_t             ptr;
    logic                live, live_rd, live_wr, accept;
    logic [ADDR_W-1:0]   live_adr;
    logic [DATA_W-1:0]   live_wd;
    logic [BE_W-1:0]     live_be;
    logic                hold_rd, hold_wr;
    logic [ADDR_W-1:0]   hold_adr;
    logic [DATA_W-1:0]   hold_wd;
    logic [BE_W-1:0]     hold_be;
    logic [NUM_CH-1:0]   rdv_p1;

    assign req  = ch_read | ch_write;
    assign both = ch_read & ch_write;

    mips_bus_arb_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant)
    );

`ifdef MIPS_BUS_ARB_RR_EN
    ch_idx_t ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept && grant[i]) ptr_nxt = next_ch(i, NUM_CH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= '0;
        else       ptr <= ptr_nxt;
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if ((read | write) && waitrequest) state_nxt = LOCKED;
            LOCKED:  if (!waitrequest) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus mux: a frozen owner that drops its request keeps the bus on held values.
    always_comb begin
        grant = '0;
        if (armed) grant = (state == LOCKED) ? lock_grant : pick_grant;
        live     = |(req & grant);
        live_rd  = |(ch_read & ~ch_write & grant);
        live_wr  = |(ch_write & grant);
        live_adr = '0;
        live_wd  = '0;
        live_be  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                live_adr = ch_address[i*ADDR_W +: ADDR_W];
                live_wd  = ch_writedata[i*DATA_W +: DATA_W];
                live_be  = ch_byteenable[i*BE_W +: BE_W];
            end
        end
        if (state == LOCKED && !live) begin
            read       = hold_rd;
            write      = hold_wr;
            address    = hold_adr;
            writedata  = hold_wd;
            byteenable = hold_be;
        end else begin
            read       = live_rd;
            write      = live_wr;
            address    = live_adr;
            writedata  = live_wd;
            byteenable = live_be;
        end
        accept           = (read | write) & ~waitrequest;
        ch_waitrequest   = req & ~(grant & {NUM_CH{accept}});
        ch_readdatavalid = rdv_p1;
        ch_readdata      = (|rdv_p1) ? readdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed      <= 1'b0;
            lock_grant <= '0;
            hold_rd    <= 1'b0;
            hold_wr    <= 1'b0;
            rdv_p1     <= '0;
            proto_err  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (state == IDLE && state_nxt == LOCKED) lock_grant <= grant;
            if ((read | write) && waitrequest) begin
                hold_rd <= read;
                hold_wr <= write;
            end
            // Accept cycle -> return strobe one cycle later
            rdv_p1 <= (accept && read) ? grant : '0;
            if ((|both) || (state == LOCKED && !live)) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((read | write) && waitrequest) begin
            hold_adr <= address;
            hold_wd  <= writedata;
            hold_be  <= byteenable;
        end
    end

endmodule
